// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control, valid
// qualifier, registered one-cycle detect pulse and saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             pattern_load,
  input  logic             overlap_en,
  input  logic             count_clr,
  output logic             data_out,
  output logic [CNT_W-1:0] match_count
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_reg, hist_next;
  logic [PAT_W-1:0]  pat_reg, pat_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              data_out_reg, data_out_next;
  logic [PAT_W-1:0]  pat_default;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              match;

  // Reset pattern has only its end bits set ("101" for a 3-bit pattern).
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_pat_default
      assign pat_default[gi] = (gi == 0) || (gi == PAT_W - 1);
    end
  endgenerate

  assign hist_shift = {hist_reg[PAT_W-2:0], data_in};
  assign fill_inc   = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + FILL_W'(1);

  always_comb begin
    hist_next     = hist_reg;
    fill_next     = fill_reg;
    pat_next      = pat_reg;
    data_out_next = 1'b0;
    match         = 1'b0;
    if (pattern_load) begin
      // A bit arriving with the load strobe is discarded.
      pat_next  = pattern;
      hist_next = '0;
      fill_next = '0;
    end else if (in_valid) begin
      hist_next     = hist_shift;
      match         = (fill_inc == FILL_MAX) && (hist_shift == pat_reg);
      fill_next     = (match && !overlap_en) ? '0 : fill_inc;
      data_out_next = match;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (count_clr) begin
      count_next = '0;
    end else if (match && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg     <= '0;
      fill_reg     <= '0;
      pat_reg      <= pat_default;
      count_reg    <= '0;
      data_out_reg <= 1'b0;
    end else begin
      hist_reg     <= hist_next;
      fill_reg     <= fill_next;
      pat_reg      <= pat_next;
      count_reg    <= count_next;
      data_out_reg <= data_out_next;
    end
  end

  assign data_out    = data_out_reg;
  assign match_count = count_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench: a 3-bit detector with a 2-bit counter and a
// 4-bit detector with an 8-bit counter share one stimulus bus.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       pattern_load = 1'b0;
  logic       overlap_en = 1'b1;
  logic       count_clr = 1'b0;
  logic [2:0] pattern3 = 3'b000;
  logic [3:0] pattern4 = 4'b0000;
  logic       do3, do4;
  logic [1:0] cnt3;
  logic [7:0] cnt4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .pattern(pattern3), .pattern_load(pattern_load), .overlap_en(overlap_en),
    .count_clr(count_clr), .data_out(do3), .match_count(cnt3)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .pattern(pattern4), .pattern_load(pattern_load), .overlap_en(overlap_en),
    .count_clr(count_clr), .data_out(do4), .match_count(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check({tag, "_do3"}, 32'(do3), 32'd0);
    check({tag, "_cnt3"}, 32'(cnt3), 32'd0);
    check({tag, "_do4"}, 32'(do4), 32'd0);
    check({tag, "_cnt4"}, 32'(cnt4), 32'd0);
  endtask

  // bits[n-1] goes on the wire first; pulses holds the expected data_out after each bit.
  task automatic feed(input int which, input string tag, input logic [15:0] bits,
                      input logic [15:0] pulses, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in  = bits[i];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("%s_bit%0d", tag, n - i), 32'((which == 3) ? do3 : do4), 32'(pulses[i]));
    end
  endtask

  task automatic load(input logic [2:0] p3, input logic [3:0] p4);
    pattern3     = p3;
    pattern4     = p4;
    pattern_load = 1'b1;
    tick();
    pattern_load = 1'b0;
  endtask

  initial begin
    do_reset("rst0");

    // Default 101, overlapping
    overlap_en = 1'b1;
    feed(3, "t1", 16'b0101011, 16'b0001010, 7);
    check("t1_cnt", 32'(cnt3), 32'd2);

    // Default 101, non-overlapping
    do_reset("rst2");
    overlap_en = 1'b0;
    feed(3, "t2", 16'b0101011, 16'b0001000, 7);
    check("t2_cnt", 32'(cnt3), 32'd1);
    overlap_en = 1'b1;

    // Reset in the middle of a partial match
    do_reset("rst3");
    feed(3, "t3a", 16'b10, 16'b00, 2);
    do_reset("rst3b");
    feed(3, "t3b", 16'b101, 16'b001, 3);
    check("t3_cnt", 32'(cnt3), 32'd1);

    // Runtime load of 1101 with idle gaps inside the match
    do_reset("rst4");
    load(3'b101, 4'b1101);
    feed(4, "t4a", 16'b11, 16'b00, 2);
    for (int g = 0; g < 3; g++) begin
      tick();
      check($sformatf("t4_gap%0d", g), 32'(do4), 32'd0);
    end
    feed(4, "t4b", 16'b01, 16'b01, 2);
    check("t4_cnt", 32'(cnt4), 32'd1);

    // Load coinciding with the third bit drops that bit
    load(3'b101, 4'b1101);
    feed(4, "t4c", 16'b11, 16'b00, 2);
    data_in      = 1'b0;
    in_valid     = 1'b1;
    pattern_load = 1'b1;
    tick();
    pattern_load = 1'b0;
    in_valid     = 1'b0;
    check("t4_loadbit", 32'(do4), 32'd0);
    feed(4, "t4d", 16'b1, 16'b0, 1);
    check("t4_cnt2", 32'(cnt4), 32'd1);

    // Saturating 2-bit counter, then clear racing a match
    do_reset("rst5");
    feed(3, "t5", 16'b10101010101, 16'b00101010101, 11);
    check("t5_sat", 32'(cnt3), 32'd3);
    feed(3, "t5b", 16'b0, 16'b0, 1);
    count_clr = 1'b1;
    feed(3, "t5c", 16'b1, 16'b1, 1);
    count_clr = 1'b0;
    check("t5_clr", 32'(cnt3), 32'd0);

    // All-zero pattern: fill gating prevents a false match on reset history
    do_reset("rst6");
    load(3'b000, 4'b0000);
    feed(3, "t6a", 16'b00, 16'b00, 2);
    feed(3, "t6b", 16'b0, 16'b1, 1);
    tick();
    check("t6_gap", 32'(do3), 32'd0);
    feed(3, "t6c", 16'b0, 16'b1, 1);
    check("t6_cnt", 32'(cnt3), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
